// File: rtl/stream_pattern_counter_pkg.sv
// Shared definitions for the streaming pattern counter.
// Provides width helpers for per-word match counts and skip counters,
// and the scan mode encoding used by the scanner and the top level.
package spc_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } scan_mode_e;

    // Width needed to hold a per-word count of 0..data_w matches.
    function automatic int calc_wc_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Width of the pending-skip counter (0..pat_w-1); at least one bit.
    function automatic int calc_sk_w(input int pat_w);
        return (pat_w > 1) ? $clog2(pat_w) : 1;
    endfunction

    // Carry register width; a 1-bit pattern needs no carry but keeps one dummy bit.
    function automatic int calc_carry_w(input int pat_w);
        return (pat_w > 1) ? pat_w - 1 : 1;
    endfunction

endpackage

// File: rtl/stream_pattern_counter_if.sv
// Stream bundle for the pattern counter.
//  in_valid/in_ready/in_data/in_last : input word stream, framed by in_last
//  out_valid/out_ready               : frame result handshake
//  frame_count/frame_sat             : frame result payload
// master = source/sink side, slave = counter side.
interface stream_pattern_counter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, frame_count, frame_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, frame_count, frame_sat
    );
endinterface

// File: rtl/stream_pattern_counter_scan.sv
// pattern_word_scan: combinational match counter for one stream word.
//  word       : current word, bit 0 earliest in time
//  carry      : last PAT_W-1 bits of the previous word of the frame
//  skip_in    : start positions still to be skipped after an earlier match
//  first      : word is the first of its frame (no carry windows)
//  pattern    : pattern[k] matches stream bit pos+k
//  mode       : overlapping / non-overlapping
//  word_count : matches starting in this word's window positions
//  skip_out   : skip still pending after the last position of the word
module pattern_word_scan
    import spc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PAT_W   = 3,
    parameter int WC_W    = calc_wc_w(DATA_W),
    parameter int SK_W    = calc_sk_w(PAT_W),
    parameter int CARRY_W = calc_carry_w(PAT_W)
) (
    input  logic [DATA_W-1:0]  word,
    input  logic [CARRY_W-1:0] carry,
    input  logic [SK_W-1:0]    skip_in,
    input  logic               first,
    input  logic [PAT_W-1:0]   pattern,
    input  scan_mode_e         mode,
    output logic [WC_W-1:0]    word_count,
    output logic [SK_W-1:0]    skip_out
);
    // With PAT_W=1 the single carry bit is an unused dummy, so windows start one bit higher.
    localparam int OFF = CARRY_W - (PAT_W - 1);

    logic [DATA_W+CARRY_W-1:0] ext;
    logic [WC_W-1:0]           cnt;
    logic [SK_W-1:0]           sk;

    assign ext = {word, carry};

    // Position j is the window ending at word bit j+PAT_W-1-(PAT_W-1); the first
    // PAT_W-1 positions reach into the carry and are invalid on a frame's first word.
    always_comb begin
        cnt = '0;
        sk  = skip_in;
        for (int j = 0; j < DATA_W; j++) begin
            if (!first || (j >= PAT_W - 1)) begin
                if (sk != '0) begin
                    sk = sk - SK_W'(1);
                end else if (ext[j+OFF +: PAT_W] == pattern) begin
                    cnt = cnt + WC_W'(1);
                    if (mode == MODE_NONOVL) begin
                        sk = SK_W'(PAT_W - 1);
                    end
                end
            end
        end
        word_count = cnt;
        skip_out   = sk;
    end
endmodule

// File: rtl/stream_pattern_counter.sv
// stream_pattern_counter: counts PAT_W-bit pattern matches across each frame
// of a valid/ready word stream, including matches spanning word boundaries.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : synchronous abort of frame state and pending result
//  mode_ovl   : 1 = overlapping matches (latched at frame start)
//  pattern    : match pattern (latched at frame start)
//  bus        : input stream and result handshake (slave side)
module stream_pattern_counter
    import spc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     mode_ovl,
    input  logic [PAT_W-1:0]         pattern,
    stream_pattern_counter_if.slave  bus
);
    localparam int WC_W    = calc_wc_w(DATA_W);
    localparam int SK_W    = calc_sk_w(PAT_W);
    localparam int CARRY_W = calc_carry_w(PAT_W);
    // Wide enough that accum + word_count never wraps, whichever operand is wider.
    localparam int SUM_W   = ((CNT_W > WC_W) ? CNT_W : WC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic             ovf;
        logic [CNT_W-1:0] val;
    } sat_sum_t;

    logic [PAT_W-1:0]   pat_q;
    scan_mode_e         mode_q;
    logic               in_frame;
    logic [CARRY_W-1:0] carry_q;
    logic [SK_W-1:0]    skip_q;
    logic [CNT_W-1:0]   accum_q;
    logic               sat_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   count_q;
    logic               frame_sat_q;

    logic               accept;
    logic [PAT_W-1:0]   pat_eff;
    scan_mode_e         mode_eff;
    logic [SK_W-1:0]    skip_eff;
    logic [WC_W-1:0]    word_count;
    logic [SK_W-1:0]    skip_next;
    logic [SUM_W-1:0]   sum;
    sat_sum_t           acc_next;
    logic               sat_next;

    assign bus.in_ready    = !out_valid_q || bus.out_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_count = count_q;
    assign bus.frame_sat   = frame_sat_q;

    assign accept   = bus.in_valid && bus.in_ready && !clear;
    // The first beat of a frame scans with the live settings, which are latched for the rest.
    assign pat_eff  = in_frame ? pat_q  : pattern;
    assign mode_eff = in_frame ? mode_q : scan_mode_e'(mode_ovl);
    assign skip_eff = in_frame ? skip_q : '0;

    pattern_word_scan #(
        .DATA_W  (DATA_W),
        .PAT_W   (PAT_W),
        .WC_W    (WC_W),
        .SK_W    (SK_W),
        .CARRY_W (CARRY_W)
    ) u_scan (
        .word       (bus.in_data),
        .carry      (carry_q),
        .skip_in    (skip_eff),
        .first      (!in_frame),
        .pattern    (pat_eff),
        .mode       (mode_eff),
        .word_count (word_count),
        .skip_out   (skip_next)
    );

    always_comb begin
        sum = SUM_W'(accum_q) + SUM_W'(word_count);
        if (sum > SUM_W'(CNT_MAX)) begin
            acc_next.ovf = 1'b1;
            acc_next.val = CNT_MAX;
        end else begin
            acc_next.ovf = 1'b0;
            acc_next.val = sum[CNT_W-1:0];
        end
        sat_next = sat_q || acc_next.ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q       <= '0;
            mode_q      <= MODE_NONOVL;
            in_frame    <= 1'b0;
            carry_q     <= '0;
            skip_q      <= '0;
            accum_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            frame_sat_q <= 1'b0;
        end else if (clear) begin
            in_frame    <= 1'b0;
            carry_q     <= '0;
            skip_q      <= '0;
            accum_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            frame_sat_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (!in_frame) begin
                    pat_q  <= pattern;
                    mode_q <= scan_mode_e'(mode_ovl);
                end
                if (bus.in_last) begin
                    out_valid_q <= 1'b1;
                    count_q     <= acc_next.val;
                    frame_sat_q <= sat_next;
                    in_frame    <= 1'b0;
                    carry_q     <= '0;
                    skip_q      <= '0;
                    accum_q     <= '0;
                    sat_q       <= 1'b0;
                end else begin
                    in_frame    <= 1'b1;
                    carry_q     <= bus.in_data[DATA_W-1 -: CARRY_W];
                    skip_q      <= skip_next;
                    accum_q     <= acc_next.val;
                    sat_q       <= sat_next;
                end
            end
        end
    end
endmodule
